hazard_tracking_unit: RTL and testbench
=======================================

Name: hazard_tracking_unit

Overview:
- Producer side of the EX-stage forwarding interface.
- Tracks destination register and write-enable of in-flight instructions through EX->MEM->WB and drives RD_M, RD_W, RegWriteM and RegWriteW to the forwarding logic.
- Generates pipeline stall/flush controls for load-use hazards, taken branches and multi-cycle data-memory accesses, with a bounded-wait timeout FSM.
- Sits beside the five-stage datapath; all pipeline register enables and clears come from here.

Parameters:
- REG_ADDR_W, 5, register index width.
- MEM_TIMEOUT, 16, maximum wait cycles on a memory request before an error abort; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- RS1_D  in  REG_ADDR_W  source 1 of the instruction in decode.
- RS2_D  in  REG_ADDR_W  source 2 of the instruction in decode.
- RD_E  in  REG_ADDR_W  destination of the instruction in execute.
- RegWriteE  in  1  execute instruction writes the register file.
- LoadE  in  1  execute instruction is a load (result comes from memory).
- PCSrcE  in  1  taken branch or jump resolved in execute.
- MemReqM  in  1  memory-stage instruction issues a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- RD_M  out  REG_ADDR_W  registered destination in the MEM stage.
- RD_W  out  REG_ADDR_W  registered destination in the WB stage.
- RegWriteM  out  1  registered write enable in the MEM stage.
- RegWriteW  out  1  registered write enable in the WB stage.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC and the corresponding pipeline registers.
- FlushD, FlushE  out  1 each  clear the D and E pipeline registers to a bubble.
- MemErr  out  1  one-cycle pulse when a memory access times out.

Behaviour:
- Reset (rst==0 at a clock edge):
  - RD_M, RD_W, RegWriteM, RegWriteW, LoadM and MemErr are cleared to 0.
  - The wait counter clears to 0 and the FSM enters IDLE.
  - A reset during WAIT aborts the access and does not pulse MemErr.
- FSM states: IDLE, WAIT, ABORT.
  - IDLE: MemReqM & !MemReadyM moves to WAIT with the counter set to 1. Otherwise the FSM stays in IDLE.
  - WAIT: MemReadyM returns to IDLE. Counter == MEM_TIMEOUT-1 with !MemReadyM moves to ABORT. Otherwise the counter increments.
  - ABORT: lasts exactly one cycle, with MemErr=1, then returns to IDLE.
- mem_stall = (IDLE & MemReqM & !MemReadyM) | (WAIT & !MemReadyM). It is combinational and does not stall in the cycle MemReadyM rises.
- While mem_stall:
  - StallF, StallD, StallE and StallM are all 1.
  - The E->M tracking registers hold.
  - The M->W registers load a bubble (RD_W<=0, RegWriteW<=0).
- In ABORT:
  - The stalls are released.
  - The M->W registers load a bubble, so the aborted instruction never writes back.
  - E->M advances normally.
- Load-use hazard, lu:
  - lu = LoadE & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D).
  - When lu & !PCSrcE & !mem_stall: StallF=1, StallD=1 and FlushE=1. Exactly one bubble is inserted.
- Branch: PCSrcE & !mem_stall drives FlushD=1 and FlushE=1, with no stalls. While mem_stall is active the flush is deferred, because PCSrcE is held by StallE.
- Priority: mem_stall, then branch, then load-use.
- Normal advance (no mem_stall):
  - RD_M<=RD_E and LoadM<=LoadE.
  - RegWriteM<=RegWriteE & (RD_E!=0).
  - When FlushE is asserted, RegWriteM<=0 and RD_M<=0.
  - RD_W<=RD_M and RegWriteW<=RegWriteM.
- RegWriteM and RegWriteW are never 1 with a zero destination.
- All stall and flush outputs are combinational from the current inputs and state. Tracking outputs have a 1-cycle latency per stage.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/ABORT), REG_ADDR_W default, ZERO_REG constant.
- One sub-module, mem_wait_fsm: takes MemReqM and MemReadyM, and produces mem_stall, abort and MemErr together with the counter.

Test Plan:
- Load-use. Drive LoadE=1, RD_E=5, RegWriteE=1, RS1_D=5. Required response: StallF=StallD=FlushE=1 for 1 cycle. The next cycle gives RD_M=0 and RegWriteM=0, then normal flow resumes.
- Branch priority. Drive PCSrcE=1 together with the load-use condition above. Required response: FlushD=FlushE=1 and StallF=StallD=0.
- Tracking. Over three cycles drive RD_E=3/7/0, all with RegWriteE=1. Required response: RD_M shows 3, then 7, then 0 with RegWriteM=1,1,0. RD_W lags RD_M by one cycle.
- Memory wait. Drive MemReqM=1 with MemReadyM low for 3 cycles. Required response: all four stalls are 1 for 3 cycles, RD_M holds, and RegWriteW=0 during the wait. Stalls drop in the cycle MemReadyM=1.
- Timeout. Use MEM_TIMEOUT=4 and hold MemReadyM=0. Required response: stalls for 4 cycles, then MemErr=1 for one cycle with stalls released. RegWriteW stays 0 for the aborted instruction, and the FSM is back in IDLE afterwards.
- Reset mid-wait. Drive rst=0 during the 2nd WAIT cycle. Required response: next cycle all outputs are 0, the FSM is in IDLE, and MemErr is never pulsed.

Source files
------------

// File: rtl/hazard_tracking_unit_pkg.sv
// hazard_tracking_unit_pkg: shared FSM encoding and register-index constants
package hazard_tracking_unit_pkg;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int ZERO_REG       = 0;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: bounded wait on a multi-cycle data-memory access, aborting on timeout
module mem_wait_fsm
    import hazard_tracking_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_i,
    input  logic mem_ready_i,
    output logic mem_stall_o,
    output logic abort_o,
    output logic mem_err_o
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (mem_req_i && !mem_ready_i) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_ONE;
            end
        end else if (state_q == ST_WAIT) begin
            if (mem_ready_i) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_ABORT;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // no stall in the cycle ready rises, so the access completes without a dead cycle
    assign mem_stall_o = !mem_ready_i && ((state_q == ST_IDLE && mem_req_i) || state_q == ST_WAIT);
    assign abort_o     = state_q == ST_ABORT;
    assign mem_err_o   = abort_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/hazard_tracking_unit.sv
// hazard_tracking_unit: tracks EX->MEM->WB destinations for forwarding and drives stall/flush controls
module hazard_tracking_unit
    import hazard_tracking_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] RS1_D,
    input  logic [REG_ADDR_W-1:0] RS2_D,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic                  RegWriteE,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [REG_ADDR_W-1:0] RD_W,
    output logic                  RegWriteM,
    output logic                  RegWriteW,
    output logic                  LoadM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MemErr
);
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

    logic                  mem_stall, abort, lu, flush_e, bubble_w, rd_e_nz;
    logic [REG_ADDR_W-1:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic                  rw_m_q, rw_m_d, rw_w_q, rw_w_d, ld_m_q, ld_m_d;

    mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_req_i  (MemReqM),
        .mem_ready_i(MemReadyM),
        .mem_stall_o(mem_stall),
        .abort_o    (abort),
        .mem_err_o  (MemErr)
    );

    assign rd_e_nz = RD_E != ZERO;
    assign lu      = LoadE && rd_e_nz && (RD_E == RS1_D || RD_E == RS2_D);
    // memory stall dominates: a held PCSrcE re-resolves once the stall lifts
    assign flush_e = !mem_stall && (PCSrcE || lu);
    assign StallF  = mem_stall || (lu && !PCSrcE);
    assign StallD  = StallF;
    assign StallE  = mem_stall;
    assign StallM  = mem_stall;
    assign FlushD  = !mem_stall && PCSrcE;
    assign FlushE  = flush_e;

    // an aborted or still-waiting MEM instruction must never reach write-back
    assign bubble_w = mem_stall || abort;
    assign rd_m_d   = mem_stall ? rd_m_q : (flush_e ? ZERO : RD_E);
    assign rw_m_d   = mem_stall ? rw_m_q : (!flush_e && RegWriteE && rd_e_nz);
    assign ld_m_d   = mem_stall ? ld_m_q : (!flush_e && LoadE);
    assign rd_w_d   = bubble_w ? ZERO : rd_m_q;
    assign rw_w_d   = !bubble_w && rw_m_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_m_q <= ZERO;
            rd_w_q <= ZERO;
            rw_m_q <= 1'b0;
            rw_w_q <= 1'b0;
            ld_m_q <= 1'b0;
        end else begin
            rd_m_q <= rd_m_d;
            rd_w_q <= rd_w_d;
            rw_m_q <= rw_m_d;
            rw_w_q <= rw_w_d;
            ld_m_q <= ld_m_d;
        end
    end

    assign RD_M      = rd_m_q;
    assign RD_W      = rd_w_q;
    assign RegWriteM = rw_m_q;
    assign RegWriteW = rw_w_q;
    assign LoadM     = ld_m_q;
endmodule

// File: tb/tb_hazard_tracking_unit.sv
// tb_hazard_tracking_unit: scoreboard bench, expected output words queued per driven vector
module tb_hazard_tracking_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       reg_write_e, load_e, pc_src_e, mem_req_m, mem_ready_m;
    logic [4:0] rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_m;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    hazard_tracking_unit #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .RS1_D    (rs1_d),
        .RS2_D    (rs2_d),
        .RD_E     (rd_e),
        .RegWriteE(reg_write_e),
        .LoadE    (load_e),
        .PCSrcE   (pc_src_e),
        .MemReqM  (mem_req_m),
        .MemReadyM(mem_ready_m),
        .RD_M     (rd_m),
        .RD_W     (rd_w),
        .RegWriteM(reg_write_m),
        .RegWriteW(reg_write_w),
        .LoadM    (load_m),
        .StallF   (stall_f),
        .StallD   (stall_d),
        .StallE   (stall_e),
        .StallM   (stall_m),
        .FlushD   (flush_d),
        .FlushE   (flush_e),
        .MemErr   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h exp %05h", tag, got, exp);
        end
    endtask

    // flags = {RegWriteM, RegWriteW, LoadM, StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr}
    task automatic step(input string tag, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rde, input logic rwe, input logic lde, input logic pcs,
                        input logic req, input logic rdy,
                        input logic [4:0] erdm, input logic [4:0] erdw, input logic [9:0] flags);
        logic [19:0] got;
        @(posedge clk);
        #1;
        rst = r; rs1_d = rs1; rs2_d = rs2; rd_e = rde; reg_write_e = rwe;
        load_e = lde; pc_src_e = pcs; mem_req_m = req; mem_ready_m = rdy;
        exp_q.push_back({erdm, erdw, flags});
        tag_q.push_back(tag);
        @(negedge clk);
        got = {rd_m, rd_w, reg_write_m, reg_write_w, load_m, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, mem_err};
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b0; rs1_d = '0; rs2_d = '0; rd_e = '0; reg_write_e = 1'b0;
        load_e = 1'b0; pc_src_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
        repeat (2) @(posedge clk);
        //    tag          rst rs1 rs2 rde rwe lde pcs req rdy  rdm rdw  flags
        step("reset",      0,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("idle",       1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("trk_3",      1,  0,  0,  3,  1,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("trk_7",      1,  0,  0,  7,  1,  0,  0,  0,  0,   3,  0,  10'b100_0000_00_0);
        step("trk_0",      1,  0,  0,  0,  1,  0,  0,  0,  0,   7,  3,  10'b110_0000_00_0);
        step("trk_drain",  1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  7,  10'b010_0000_00_0);
        step("lu_rs1",     1,  5,  0,  5,  1,  1,  0,  0,  0,   0,  0,  10'b000_1100_01_0);
        step("lu_bubble",  1,  5,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("lu_resume",  1,  0,  2,  9,  1,  1,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("load_in_m",  1,  0,  0,  0,  0,  0,  0,  0,  0,   9,  0,  10'b101_0000_00_0);
        step("br_prio",    1,  5,  0,  5,  1,  1,  1,  0,  0,   0,  9,  10'b010_0000_11_0);
        step("br_flushed", 1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("lu_x0",      1,  0,  0,  0,  1,  1,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("lu_rs2",     1,  0,  4,  4,  1,  1,  0,  0,  0,   0,  0,  10'b001_1100_01_0);
        step("lu_rs2_bub", 1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("mw_pre",     1,  0,  0,  6,  1,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("mw_1",       1,  0,  0,  8,  1,  0,  0,  1,  0,   6,  0,  10'b100_1111_00_0);
        step("mw_2",       1,  0,  0,  8,  1,  0,  0,  1,  0,   6,  0,  10'b100_1111_00_0);
        step("mw_3",       1,  0,  0,  8,  1,  0,  0,  1,  0,   6,  0,  10'b100_1111_00_0);
        step("mw_ready",   1,  0,  0,  8,  1,  0,  0,  1,  1,   6,  0,  10'b100_0000_00_0);
        step("mw_adv1",    1,  0,  0,  0,  0,  0,  0,  0,  0,   8,  6,  10'b110_0000_00_0);
        step("mw_adv2",    1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  8,  10'b010_0000_00_0);
        step("to_pre",     1,  0,  0,  2,  1,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("to_w1",      1,  0,  0, 11,  1,  0,  0,  1,  0,   2,  0,  10'b100_1111_00_0);
        step("to_w2",      1,  0,  0, 11,  1,  0,  0,  1,  0,   2,  0,  10'b100_1111_00_0);
        step("to_w3",      1,  0,  0, 11,  1,  0,  0,  1,  0,   2,  0,  10'b100_1111_00_0);
        step("to_w4",      1,  0,  0, 11,  1,  0,  0,  1,  0,   2,  0,  10'b100_1111_00_0);
        step("to_abort",   1,  0,  0, 11,  1,  0,  0,  0,  0,   2,  0,  10'b100_0000_00_1);
        step("to_no_wb",   1,  0,  0,  0,  0,  0,  0,  0,  0,  11,  0,  10'b100_0000_00_0);
        step("to_idle_rdy",1,  0,  0,  0,  0,  0,  0,  1,  1,   0, 11,  10'b010_0000_00_0);
        step("rw_req",     1,  0,  0,  0,  0,  0,  0,  1,  0,   0,  0,  10'b000_1111_00_0);
        step("rw_br_defer",1,  5,  0,  5,  1,  1,  1,  1,  0,   0,  0,  10'b000_1111_00_0);
        step("rw_rst",     0,  0,  0,  5,  1,  0,  0,  0,  0,   0,  0,  10'b000_1111_00_0);
        step("rw_after",   1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("rw_no_err1", 1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        step("rw_no_err2", 1,  0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  10'b000_0000_00_0);
        check("sb_empty", 20'(exp_q.size()), 20'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
